// File: rtl/jk_flipflop.sv
// Bank of WIDTH independent JK bit-cells; q updates one rising edge after j/k are sampled.
// No flow control; async active-high reset on rst_n overrides clocking and loads RESET_VALUE.
module jk_flipflop #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] q_nxt;

  // Characteristic equation: J sets a cleared bit, a set bit survives unless K.
  always_comb begin
    q_nxt = (j & ~q) | (~k & q);
  end

  // rst_n is asserted high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      q <= RESET_VALUE;
    end else begin
      q <= q_nxt;
    end
  end

  assign q_bar = ~q;

endmodule

// File: tb/tb_jk_flipflop.sv
// Directed checks of the JK bank: reset, hold/clear/set/toggle, mid-cycle reset and input glitches.
module tb_jk_flipflop;

  logic       clk;
  logic       rst_n;
  logic       j1, k1;
  logic       q1, qb1;
  logic [3:0] j4, k4;
  logic [3:0] q4, qb4;
  int         checks;
  int         errors;

  jk_flipflop #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .j     (j1),
    .k     (k1),
    .q     (q1),
    .q_bar (qb1)
  );

  jk_flipflop #(.WIDTH(4), .RESET_VALUE(4'b0011)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .j     (j4),
    .k     (k4),
    .q     (q4),
    .q_bar (qb4)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One full clock period; returns with clk low, well away from the edge.
  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic exp_q);
    chk({tag, "_q"},    {3'b000, q1},  {3'b000, exp_q});
    chk({tag, "_qbar"}, {3'b000, qb1}, {3'b000, ~exp_q});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    j1 = 1'b0; k1 = 1'b0;
    j4 = 4'b0000; k4 = 4'b0000;

    // Reset with clock idle.
    #1 rst_n = 1'b1;
    #1;
    chk1("reset_idle", 1'b0);
    chk("reset4_q",    q4,  4'b0011);
    chk("reset4_qbar", qb4, 4'b1100);

    rst_n = 1'b0;
    #2;
    j1 = 1'b0; k1 = 1'b0; tick(); chk1("hold00", 1'b0);
    j1 = 1'b0; k1 = 1'b1; tick(); chk1("clear01", 1'b0);
    j1 = 1'b1; k1 = 1'b0; tick(); chk1("set10", 1'b1);
    j1 = 1'b1; k1 = 1'b1; tick(); chk1("toggle11_a", 1'b0);
    tick(); chk1("toggle11_b", 1'b1);
    tick(); chk1("toggle11_c", 1'b0);
    tick(); chk1("toggle11_d", 1'b1);

    // Mid-cycle reset with q=1 and jk=11 pending.
    #2 rst_n = 1'b1;
    #1;
    chk1("midreset", 1'b0);
    tick(); chk1("reset_edge_11", 1'b0);
    j1 = 1'b1; k1 = 1'b0;
    tick(); chk1("reset_edge_10", 1'b0);

    // First edge after deassert starts from RESET_VALUE.
    rst_n = 1'b0;
    tick(); chk1("post_reset_set", 1'b1);

    // Reset raised together with a rising edge while jk=10 would keep q=1.
    #5;
    clk = 1'b1;
    rst_n = 1'b1;
    #1;
    chk1("reset_vs_edge", 1'b0);
    #4 clk = 1'b0;
    rst_n = 1'b0;
    tick(); chk1("post_reset_set2", 1'b1);

    // Glitch on k between edges must not clear q.
    j1 = 1'b0; k1 = 1'b1;
    #2 k1 = 1'b0;
    tick(); chk1("glitch_k", 1'b1);
    j1 = 1'b0; k1 = 1'b1;
    tick(); chk1("clear_again", 1'b0);
    // 00 -> 10 -> 00 before the edge must not set q.
    j1 = 1'b0; k1 = 1'b0;
    #1 j1 = 1'b1;
    #2 j1 = 1'b0;
    tick(); chk1("glitch_j", 1'b0);

    // Wide bank: edges so far held 0011 with jk=00.
    chk("w4_hold_q", q4, 4'b0011);
    j4 = 4'b1010; k4 = 4'b0110;
    tick();
    chk("w4_mix_q",    q4,  4'b1001);
    chk("w4_mix_qbar", qb4, 4'b0110);
    tick();
    chk("w4_mix2_q",    q4,  4'b1011);
    chk("w4_mix2_qbar", qb4, 4'b0100);
    #2 rst_n = 1'b1;
    #1;
    chk("w4_midreset_q", q4, 4'b0011);
    rst_n = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
